// File: rtl/iter_alu.sv
// iter_alu: registered RV32I/RV64I integer ALU with valid/ready handshakes on both sides.
// Define ALU_MULDIV_EN to build the iterative RV-M multiply/divide unit (XLEN cycles per op).
module iter_alu #(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      funct,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] res,
    output logic            zero,
    output logic            busy
);

`ifdef ALU_MULDIV_EN
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, DONE} state_t;
`endif

    state_t          state_q, state_d;
    logic [XLEN-1:0] res_d;
    logic            zero_d;
    logic [XLEN-1:0] alu_res;
    logic [SHW-1:0]  shamt;

    always_comb begin
        shamt   = op2[SHW-1:0];
        alu_res = '0;
        case (funct)
            5'd0:    alu_res = op1 + op2;
            5'd1:    alu_res = op1 - op2;
            5'd2:    alu_res = op1 << shamt;
            5'd3:    alu_res = {{(XLEN-1){1'b0}}, $signed(op1) < $signed(op2)};
            5'd4:    alu_res = {{(XLEN-1){1'b0}}, op1 < op2};
            5'd5:    alu_res = op1 ^ op2;
            5'd6:    alu_res = op1 >> shamt;
            5'd7:    alu_res = $unsigned($signed(op1) >>> shamt);
            5'd8:    alu_res = op1 | op2;
            5'd9:    alu_res = op1 & op2;
            default: alu_res = '0;
        endcase
    end

`ifdef ALU_MULDIV_EN
    localparam logic [SHW-1:0] LAST = SHW'(XLEN - 1);

    logic [2:0]        mf_q, mf_d;
    logic              neg_q, neg_d;
    logic [SHW-1:0]    cnt_q, cnt_d;
    logic [XLEN-1:0]   a_q, a_d;
    logic [2*XLEN-1:0] acc_q, acc_d, step, mprod;
    logic [XLEN:0]     msum, rshift;
    logic [XLEN-1:0]   mag1, mag2, dval, md_res;
    logic              s1, s2, rge;

    // Signed ops run on magnitudes; neg_q records whether the final result is negated.
    // acc holds the shifting product for multiply and {remainder, quotient} for divide.
    always_comb begin
        if (funct[2]) begin
            s1 = ~funct[0] & op1[XLEN-1];
            s2 = ~funct[0] & op2[XLEN-1];
        end else begin
            s1 = ((funct[1:0] == 2'd1) || (funct[1:0] == 2'd2)) & op1[XLEN-1];
            s2 = (funct[1:0] == 2'd1) & op2[XLEN-1];
        end
        mag1 = s1 ? -op1 : op1;
        mag2 = s2 ? -op2 : op2;

        msum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, a_q & {XLEN{acc_q[0]}}};
        rshift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        rge    = rshift >= {1'b0, a_q};
        if (mf_q[2])
            step = {(rge ? rshift[XLEN-1:0] - a_q : rshift[XLEN-1:0]), acc_q[XLEN-2:0], rge};
        else
            step = {msum, acc_q[XLEN-1:1]};

        mprod = neg_q ? -step : step;
        dval  = mf_q[1] ? step[2*XLEN-1:XLEN] : step[XLEN-1:0];
        if (mf_q[2])
            md_res = neg_q ? -dval : dval;
        else if (mf_q[1:0] == 2'd0)
            md_res = mprod[XLEN-1:0];
        else
            md_res = mprod[2*XLEN-1:XLEN];
    end
`endif

    always_comb begin
        state_d = state_q;
        res_d   = res;
        zero_d  = zero;
`ifdef ALU_MULDIV_EN
        mf_d    = mf_q;
        neg_d   = neg_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        acc_d   = acc_q;
`endif
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
`ifdef ALU_MULDIV_EN
                    if (funct[4:3] == 2'b10) begin
                        state_d = BUSY;
                        mf_d    = funct[2:0];
                        cnt_d   = '0;
                        if (funct[2]) begin
                            // divide by zero keeps a positive all-ones quotient
                            a_d   = mag2;
                            acc_d = {{XLEN{1'b0}}, mag1};
                            neg_d = funct[1] ? s1 : ((s1 ^ s2) & (op2 != '0));
                        end else begin
                            a_d   = mag1;
                            acc_d = {{XLEN{1'b0}}, mag2};
                            neg_d = s1 ^ s2;
                        end
                    end else
`endif
                    begin
                        state_d = DONE;
                        res_d   = alu_res;
                        zero_d  = (alu_res == '0);
                    end
                end
`ifdef ALU_MULDIV_EN
                BUSY: begin
                    acc_d = step;
                    cnt_d = cnt_q + SHW'(1);
                    if (cnt_q == LAST) begin
                        state_d = DONE;
                        res_d   = md_res;
                        zero_d  = (md_res == '0);
                    end
                end
`endif
                DONE: if (out_ready) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            res     <= '0;
            zero    <= 1'b1;
`ifdef ALU_MULDIV_EN
            mf_q    <= '0;
            neg_q   <= 1'b0;
            cnt_q   <= '0;
            a_q     <= '0;
            acc_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            res     <= res_d;
            zero    <= zero_d;
`ifdef ALU_MULDIV_EN
            mf_q    <= mf_d;
            neg_q   <= neg_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            acc_q   <= acc_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
`ifdef ALU_MULDIV_EN
    assign busy = (state_q == BUSY);
`else
    assign busy = 1'b0;
`endif

endmodule

// File: tb/tb_iter_alu.sv
// Self-checking bench for iter_alu: directed vector table, corner sequences and randomized ops
// against an arithmetic reference model. Honours ALU_MULDIV_EN the same way as the design.
module tb_iter_alu;
    localparam int XLEN = 32;
`ifdef ALU_MULDIV_EN
    localparam bit MD = 1'b1;
`else
    localparam bit MD = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            flush = 1'b0;
    logic            in_valid = 1'b0;
    logic            out_ready = 1'b0;
    logic [4:0]      funct = '0;
    logic [XLEN-1:0] op1 = '0;
    logic [XLEN-1:0] op2 = '0;
    logic            in_ready, out_valid, zero, busy;
    logic [XLEN-1:0] res;

    int checks = 0;
    int errors = 0;

    iter_alu #(.XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .funct(funct),
        .op1(op1), .op2(op2),
        .out_valid(out_valid), .out_ready(out_ready),
        .res(res), .zero(zero), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic bit is_md(input logic [4:0] f);
        return MD && (f >= 5'd16) && (f <= 5'd23);
    endfunction

    function automatic int exp_lat(input logic [4:0] f);
        return is_md(f) ? XLEN + 1 : 1;
    endfunction

    function automatic logic [31:0] md(input logic [31:0] v);
        return MD ? v : 32'h0;
    endfunction

    function automatic logic [31:0] ref_alu(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b);
        int          sa, sb;
        longint      pa, pb;
        logic [63:0] p;
        sa = a;
        sb = b;
        case (f)
            5'd0: return a + b;
            5'd1: return a - b;
            5'd2: return a << b[4:0];
            5'd3: return (sa < sb) ? 32'd1 : 32'd0;
            5'd4: return (a < b) ? 32'd1 : 32'd0;
            5'd5: return a ^ b;
            5'd6: return a >> b[4:0];
            5'd7: return sa >>> b[4:0];
            5'd8: return a | b;
            5'd9: return a & b;
            default: ;
        endcase
        if (!is_md(f)) return 32'h0;
        case (f)
            5'd16: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
            5'd17: begin pa = sa; pb = sb; p = pa * pb; return p[63:32]; end
            5'd18: begin pa = sa; pb = {32'b0, b}; p = pa * pb; return p[63:32]; end
            5'd19: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            5'd20: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return sa / sb;
            end
            5'd21: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            5'd22: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return sa % sb;
            end
            5'd23: return (b == 0) ? a : a % b;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h1;
            default: return $urandom;
        endcase
    endfunction

    // Issue one op from IDLE at a negedge, wait for the result, check it, then drain it.
    task automatic run_op(input string name, input logic [4:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
        int lat;
        bit rdy_seen;
        check({name, "/in_ready"}, in_ready, 1'b1);
        funct = f; op1 = a; op2 = b; in_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        rdy_seen = 1'b0;
        while (!out_valid && lat < 200) begin
            if (in_ready) rdy_seen = 1'b1;
            @(posedge clk); @(negedge clk);
            lat++;
        end
        check({name, "/latency"}, lat, exp_lat(f));
        check({name, "/res"}, res, exp);
        check({name, "/zero"}, zero, exp == 32'h0);
        check({name, "/ready_low"}, rdy_seen, 1'b0);
        out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        out_ready = 1'b0;
        check({name, "/release"}, {out_valid, in_ready}, 2'b01);
    endtask

    typedef struct {
        string       name;
        logic [4:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];

    initial begin
        logic [31:0] saved;
        bit          seen;

        vecs.push_back('{"add_ovf",  5'd0,  32'h7FFF_FFFF, 32'h1,         32'h8000_0000});
        vecs.push_back('{"sub_zero", 5'd1,  32'd5,         32'd5,         32'h0});
        vecs.push_back('{"sra",      5'd7,  32'h8000_0000, 32'h21,        32'hC000_0000});
        vecs.push_back('{"slt",      5'd3,  32'hFFFF_FFFF, 32'h1,         32'h1});
        vecs.push_back('{"sltu",     5'd4,  32'hFFFF_FFFF, 32'h1,         32'h0});
        vecs.push_back('{"sll",      5'd2,  32'h1,         32'h3F,        32'h8000_0000});
        vecs.push_back('{"srl",      5'd6,  32'h8000_0000, 32'h4,         32'h0800_0000});
        vecs.push_back('{"xor",      5'd5,  32'hF0F0,      32'hFF00,      32'h0FF0});
        vecs.push_back('{"or",       5'd8,  32'hF0F0,      32'h0F0F,      32'hFFFF});
        vecs.push_back('{"and",      5'd9,  32'hF0F0,      32'hFF00,      32'hF000});
        vecs.push_back('{"unk31",    5'd31, 32'h1234,      32'h5678,      32'h0});
        vecs.push_back('{"unk12",    5'd12, 32'h1234,      32'h5678,      32'h0});
        vecs.push_back('{"mul",      5'd16, 32'd3,         32'd4,         md(32'd12)});
        vecs.push_back('{"mulhu",    5'd19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, md(32'hFFFF_FFFE)});
        vecs.push_back('{"mulh",     5'd17, 32'hFFFF_FFFE, 32'd3,         md(32'hFFFF_FFFF)});
        vecs.push_back('{"mulhsu",   5'd18, 32'hFFFF_FFFF, 32'd2,         md(32'hFFFF_FFFF)});
        vecs.push_back('{"div0",     5'd20, 32'd7,         32'd0,         md(32'hFFFF_FFFF)});
        vecs.push_back('{"rem0",     5'd22, 32'd7,         32'd0,         md(32'd7)});
        vecs.push_back('{"div_ovf",  5'd20, 32'h8000_0000, 32'hFFFF_FFFF, md(32'h8000_0000)});
        vecs.push_back('{"rem_ovf",  5'd22, 32'h8000_0000, 32'hFFFF_FFFF, md(32'h0)});
        vecs.push_back('{"divu",     5'd21, 32'd100,       32'd7,         md(32'd14)});
        vecs.push_back('{"remu",     5'd23, 32'd100,       32'd7,         md(32'd2)});
        vecs.push_back('{"div_neg",  5'd20, 32'hFFFF_FFF9, 32'd2,         md(32'hFFFF_FFFD)});
        vecs.push_back('{"rem_neg",  5'd22, 32'hFFFF_FFF9, 32'd2,         md(32'hFFFF_FFFF)});

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_state", {res, zero, out_valid, in_ready, busy}, {32'h0, 4'b1010});
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) run_op(vecs[i].name, vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].exp);

        // backpressure: result held while out_ready is low, pending request ignored
        funct = 5'd0; op1 = 32'd1; op2 = 32'd2; in_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        funct = 5'd1; op1 = 32'd9; op2 = 32'd4;
        check("bp_first", {out_valid, in_ready, res}, {2'b10, 32'd3});
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); @(negedge clk);
            check($sformatf("bp_hold%0d", i), {out_valid, in_ready, zero, res}, {3'b100, 32'd3});
        end
        out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        out_ready = 1'b0;
        check("bp_release", {out_valid, in_ready, res}, {2'b01, 32'd3});
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        check("bp_next", {out_valid, res}, {1'b1, 32'd5});
        out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        out_ready = 1'b0;

        // flush ten edges after accepting a DIVU
        saved = res;
        funct = 5'd21; op1 = 32'd1000; op2 = 32'd3; in_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        repeat (9) begin @(posedge clk); @(negedge clk); end
        saved = res;
        flush = 1'b1;
        @(posedge clk); @(negedge clk);
        flush = 1'b0;
        check("flush_state", {in_ready, out_valid, busy, res}, {3'b100, saved});
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); @(negedge clk);
            if (out_valid || !in_ready) seen = 1'b1;
        end
        check("flush_quiet", seen, 1'b0);

        // flush beats a simultaneous request
        flush = 1'b1; in_valid = 1'b1; funct = 5'd0; op1 = 32'd4; op2 = 32'd4;
        @(posedge clk); @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        check("flush_vs_valid", {in_ready, out_valid, res}, {2'b10, saved});

        // asynchronous reset in the middle of a multiply
        run_op("pre_reset", 5'd0, 32'd1, 32'd2, 32'd3);
        funct = 5'd16; op1 = 32'd3; op2 = 32'd4; in_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        repeat (5) begin @(posedge clk); @(negedge clk); end
        #2 rst_n = 1'b0;
        #1 check("async_reset", {res, zero, out_valid, in_ready, busy}, {32'h0, 4'b1010});
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op("post_reset_mul", 5'd16, 32'd5, 32'd6, ref_alu(5'd16, 32'd5, 32'd6));

        for (int i = 0; i < 150; i++) begin
            logic [4:0]  f;
            logic [31:0] a, b;
            f = 5'($urandom_range(0, 31));
            a = pick();
            b = pick();
            run_op($sformatf("rnd%0d_f%0d", i, f), f, a, b, ref_alu(f, a, b));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/iter_alu.md
Name: iter_alu

Overview:
- Parametrised, registered successor to the combinational ALU.
- Executes RV32I/RV64I integer ops, plus RV-M multiply/divide when the optional feature is compiled in.
- Uses valid/ready handshakes on both sides, so the execute stage can stall on multi-cycle ops.
- Sits between decode/operand-read and writeback in the multi-cycle core.

Parameters:
- XLEN, 32, operand/result width; 32 or 64.
- SHW, $clog2(XLEN), shift-amount width (derived; do not override).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous abort of any in-flight op.
- in_valid  input  1  operation request.
- in_ready  output  1  block can accept a request.
- funct  input  5  operation code.
- op1  input  XLEN  first operand.
- op2  input  XLEN  second operand.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- res  output  XLEN  registered result.
- zero  output  1  registered flag, high when res==0.
- busy  output  1  high while in BUSY state.

Behaviour:
- Opcode encoding:
  - 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND.
  - 16 MUL, 17 MULH, 18 MULHSU, 19 MULHU, 20 DIV, 21 DIVU, 22 REM, 23 REMU.
  - Any other code: res=0, single-cycle.
- Reset (async, rst_n=0): state=IDLE, out_valid=0, res=0, zero=1, busy=0, internal counter/accumulators=0. Takes effect immediately, including mid-operation; the in-flight op is lost.
- FSM states: IDLE, BUSY, DONE.
  - in_ready = (state==IDLE).
  - A request is accepted when in_valid && in_ready at a rising edge; operands and funct are captured at that edge.
- IDLE:
  - Single-cycle op accepted at edge T: res/zero written at T, out_valid=1 from T, state→DONE.
  - Mul/div op accepted: state→BUSY, cnt=0.
- BUSY:
  - One iteration per cycle; cnt increments.
  - Multiply: radix-2 shift-add over 2·XLEN-bit product, XLEN iterations.
  - Divide: restoring, XLEN iterations.
  - On the last iteration the result is written, out_valid=1, state→DONE.
  - Latency: accept edge T, out_valid high after edge T+XLEN (33 edges total for XLEN=32).
- DONE:
  - res/zero/out_valid held stable while out_ready=0.
  - Edge with out_ready=1: out_valid→0, state→IDLE.
  - No new request is accepted in the same cycle as the output handshake; minimum issue interval is 2 cycles.
- flush=1 at an edge, from any state: state→IDLE, out_valid→0, res unchanged. flush wins over in_valid in the same cycle; no op is accepted.
- Arithmetic rules:
  - All results are modulo 2^XLEN.
  - Shifts use op2[SHW-1:0] only; SRA is arithmetic on op1 interpreted as signed.
  - SLT: full signed compare. SLTU: unsigned compare. Both return 0 or 1, zero-extended.
  - MULH/MULHSU/MULHU return the upper XLEN bits. Signed operands are handled by magnitude multiply plus final negate.
- Divide corner cases:
  - DIV/DIVU by 0: quotient = all ones.
  - REM/REMU by 0: remainder = op1.
  - Signed overflow (op1 = -2^(XLEN-1), op2 = -1): DIV → op1, REM → 0.
  - Divide-by-zero and overflow still take the full XLEN cycles; latency is data-independent.
- zero = (res==0), registered together with res.

Optional Feature:
- Macro: ALU_MULDIV_EN.
- Defined: the M-extension opcodes 16–23 are implemented as described above; the BUSY state exists.
- Undefined: opcodes 16–23 behave as unknown (res=0, single-cycle). The BUSY state, counter and accumulators are not instantiated, and busy is tied to 0.

Test Plan:
- ADD 0x7FFFFFFF + 1 with out_ready=1 → res=0x80000000, zero=0, out_valid high 1 cycle after accept; SUB 5−5 → res=0, zero=1.
- SRA op1=0x80000000, op2=0x00000021 (shamt 1) → 0xC0000000; SLT −1 vs 1 → 1; SLTU 0xFFFFFFFF vs 1 → 0.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE after 32 cycles; MULH −2 × 3 → 0xFFFFFFFF; in_ready=0 throughout BUSY.
- DIV 7/0 → 0xFFFFFFFF; REM 7/0 → 7; DIV 0x80000000/−1 → 0x80000000; REM of same → 0; latency 32 in all cases.
- Backpressure: out_ready=0 for 5 cycles after result → res/out_valid stable, in_valid ignored; release → IDLE next edge, next op accepted one cycle later.
- Abort: DIVU started, flush at cycle 10 → IDLE, no out_valid; rst_n low mid-MUL → immediate res=0, out_valid=0. With ALU_MULDIV_EN undefined, MUL 3×4 → res=0 in 1 cycle.
